cache_refill_ctrl: RTL
======================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 32, address width in bits
  DATA_WIDTH, 32, memory beat and word width in bits
  BLOCK_SIZE, 16, cache line size in bytes; WORDS = BLOCK_SIZE*8/DATA_WIDTH, a power of two ≥2
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  clock; all state changes on the rising edge
  rst  in  1  reset, asynchronous, active-high
  miss_valid  in  1  cache reports a miss
  miss_addr  in  ADDR_WIDTH  byte address that missed
  miss_ready  out  1  controller can accept a miss
  mem_req_valid  out  1  line read request to memory
  mem_req_addr  out  ADDR_WIDTH  line-aligned request address
  mem_req_ready  in  1  memory accepts the request
  mem_rsp_valid  in  1  one data beat valid
  mem_rsp_data  in  DATA_WIDTH  beat data
  fill_valid  out  1  one-cycle pulse: complete line ready for the cache
  fill_addr  out  ADDR_WIDTH  line-aligned address of the filled line
  fill_data  out  WORDS*DATA_WIDTH  full line; word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
  fill_crit  out  DATA_WIDTH  word selected by the missing address's word offset
  busy  out  1  high in every state except IDLE

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, FILL and DONE.
REQ-004 In IDLE, miss_ready SHALL be 1; in every other state it SHALL be 0.
REQ-005 A miss SHALL be accepted on an edge with miss_valid=1 and miss_ready=1.
  - The block SHALL latch miss_addr, with the low log2(BLOCK_SIZE) bits zeroed, as the line address.
  - It SHALL latch the word offset miss_addr[log2(BLOCK_SIZE)-1 : log2(DATA_WIDTH/8)].
  - It SHALL move to REQ.
REQ-006 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL equal the latched line address.
  - Both SHALL stay stable until mem_req_ready=1.
  - On that edge the FSM SHALL move to FILL with the beat counter cleared to 0.
REQ-007 mem_req_valid SHALL first assert in the cycle after acceptance (one-cycle latency) and SHALL be 0 outside REQ.
REQ-008 In FILL, each edge with mem_rsp_valid=1 SHALL:
  - store mem_rsp_data into word slot beat_cnt;
  - increment beat_cnt, which is log2(WORDS) bits wide.
  - Beats SHALL be accepted back-to-back with no stall.
REQ-009 On the beat with beat_cnt = WORDS-1, the counter SHALL wrap to 0 and the FSM SHALL move to DONE.
REQ-010 In DONE (exactly one cycle):
  - fill_valid SHALL be 1;
  - fill_addr, fill_data and fill_crit SHALL be valid;
  - the next state SHALL be IDLE unconditionally.
REQ-011 fill_addr, fill_data and fill_crit SHALL hold their values until the next miss is accepted.
REQ-012 mem_rsp_valid outside FILL SHALL be ignored: no storage and no state change.
REQ-013 A miss_valid that arrives while DONE is active SHALL NOT be accepted until the IDLE cycle that follows.
REQ-014 A miss request presented in IDLE SHALL be accepted immediately, with no bubble.
REQ-015 If mem_req_ready=1 in the first REQ cycle, the transition to FILL SHALL occur on that edge.
  - A mem_rsp_valid beat in the first FILL cycle SHALL be accepted.
REQ-016 Word slots not written during the current fill SHALL retain their previous contents.
  - In normal operation all WORDS slots are rewritten on every fill.

Reset
REQ-017 While rst=1, regardless of clk, the block SHALL:
  - set the state to IDLE and beat_cnt to 0;
  - set fill_valid=0, mem_req_valid=0, busy=0 and miss_ready=1;
  - clear fill_addr, fill_data, fill_crit and mem_req_addr to 0.
REQ-018 Reset asserted mid-request or mid-fill SHALL abandon the transaction; beats arriving after reset release SHALL be ignored per REQ-012.
REQ-019 The first miss SHALL be acceptable on the first rising edge after rst deasserts.

Structure
REQ-020 A shared package, cache_pkg, SHALL hold:
  - default values of ADDR_WIDTH, DATA_WIDTH and BLOCK_SIZE;
  - the derived constants WORDS, OFFSET_BITS and WORD_SEL_BITS;
  - the refill state enum type.
REQ-021 No sub-module is required; the FSM, beat counter and line register SHALL be implemented in cache_refill_ctrl alone.

Verification
REQ-022 Basic fill (defaults):
  - Stimulus: miss_addr=0x0000_1238, memory ready immediately, beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
  - Required: mem_req_addr=0x0000_1230, then fill_valid for one cycle with fill_data={0xA3,0xA2,0xA1,0xA0}, fill_addr=0x0000_1230, fill_crit=0xA2.
REQ-023 Request backpressure:
  - Stimulus: mem_req_ready held 0 for 5 cycles.
  - Required: mem_req_valid=1 and mem_req_addr stable for all 5 cycles, no FILL entry, miss_ready=0 throughout.
REQ-024 Gapped beats:
  - Stimulus: beats with 2 idle cycles between each.
  - Required: fill_valid only after the 4th beat; data ordered as in REQ-022.
REQ-025 Stray beats and miss during DONE:
  - Stimulus: mem_rsp_valid=1 with 0xDEAD while in IDLE, then a miss_valid held during DONE.
  - Required: no state change in IDLE; the held miss is accepted in the following IDLE cycle and fill_data is unchanged until then.
REQ-026 Reset mid-fill:
  - Stimulus: assert rst after 2 of 4 beats.
  - Required: immediate IDLE with all outputs per REQ-017; the remaining 2 beats are ignored; a new miss then completes normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache line refill controller.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BLOCK_SIZE = 16;

  localparam int WORDS         = DEF_BLOCK_SIZE * 8 / DEF_DATA_WIDTH;
  localparam int OFFSET_BITS   = $clog2(DEF_BLOCK_SIZE);
  localparam int WORD_SEL_BITS = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: issues one line read, collects WORDS beats,
// then presents the complete line plus the critical (missed) word for one cycle.
//
// state | meaning
// IDLE  | waiting for a miss, miss_ready high
// REQ   | line request held on the memory port until accepted
// FILL  | collecting beats into the line buffer
// DONE  | one-cycle fill_valid pulse, then back to IDLE
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_valid,
  input  logic [ADDR_WIDTH-1:0]   miss_addr,
  output logic                    miss_ready,
  output logic                    mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic                    fill_valid,
  output logic [ADDR_WIDTH-1:0]   fill_addr,
  output logic [BLOCK_SIZE*8-1:0] fill_data,
  output logic [DATA_WIDTH-1:0]   fill_crit,
  output logic                    busy
);

  localparam int N_WORDS   = BLOCK_SIZE * 8 / DATA_WIDTH;
  localparam int OFF_BITS  = $clog2(BLOCK_SIZE);
  localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int SEL_BITS  = $clog2(N_WORDS);

  refill_state_t         state;
  logic [SEL_BITS-1:0]   beat_cnt;
  logic [SEL_BITS-1:0]   word_off;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [DATA_WIDTH-1:0] line_buf [N_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      word_off  <= '0;
      line_addr <= '0;
      for (int k = 0; k < N_WORDS; k++) line_buf[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_valid) begin
            line_addr <= {miss_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
            word_off  <= miss_addr[OFF_BITS-1:BYTE_BITS];
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            beat_cnt <= '0;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_rsp_valid) begin
            line_buf[beat_cnt] <= mem_rsp_data;
            beat_cnt           <= beat_cnt + 1'b1;
            // WORDS is a power of two, so the last beat is the all-ones count
            if (&beat_cnt) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign miss_ready    = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_addr  = line_addr;
  assign fill_valid    = (state == ST_DONE);
  assign fill_addr     = line_addr;
  assign fill_crit     = line_buf[word_off];

  for (genvar k = 0; k < N_WORDS; k++) begin : g_fill_data
    assign fill_data[k*DATA_WIDTH +: DATA_WIDTH] = line_buf[k];
  end

  // Byte-within-word address bits have no meaning for a line refill.
  if (BYTE_BITS > 0) begin : g_unused_bytes
    logic unused_byte_bits;
    assign unused_byte_bits = ^miss_addr[BYTE_BITS-1:0];
  end

endmodule
